mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one slow_memory line port between the instruction-side and data-side L2 caches. It sits between the I-side and D-side cache_L2 memory interfaces and a single slow_memory instance, replacing the current pair of dedicated memories. It grants one 128-bit line transaction at a time, round-robin by default, and routes ready/rdata back to the owner.

## Interface
Parameters:
- ADDR_W, 28, line address width (byte address bits 31:4)
- LINE_W, 128, line data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read / i_write  in  1  I-side L2 request (level, held until i_ready)
- i_addr  in  ADDR_W  I-side line address
- i_wdata  in  LINE_W  I-side write line
- i_rdata  out  LINE_W  read line returned to I-side
- i_ready  out  1  one-cycle completion pulse to I-side
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as the I-side ports, for the D-side L2
- mem_read / mem_write  out  1  request to slow_memory
- mem_addr  out  ADDR_W  line address to slow_memory
- mem_wdata  out  LINE_W  write line to slow_memory
- mem_rdata  in  LINE_W  read line from slow_memory
- mem_ready  in  1  slow_memory completion
- owner  out  2  2'b00 idle, 2'b01 I granted, 2'b10 D granted

## Operation
- States: IDLE, BUSY_I, BUSY_D. Register last_owner is 1 bit, 0 = I and 1 = D.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one side requesting (read|write): go to that side's BUSY state.
  - Both sides requesting: grant the side that is not last_owner.
- BUSY_x:
  - mem_read, mem_write, mem_addr and mem_wdata are a combinational mux of side x.
  - x_rdata = mem_rdata and x_ready = mem_ready, both combinational.
  - The other side's ready and rdata are held at 0.
- BUSY_x with mem_ready=1: go to IDLE and set last_owner to x.
- BUSY_x when side x drops read and write before ready (protocol violation): abort to IDLE; last_owner is unchanged; memory-side state is undefined.
- Same side asserts read and write together: forward both unchanged; slow_memory semantics apply. This is illegal for cache_L2.
- In IDLE all mem_* outputs are 0.
- Requests are never queued. A requester holds its request until its ready.

## Timing
- Reset values: state IDLE, last_owner=1 (I wins the first tie), every output 0, owner=00.
- Grant latency: a request sampled in IDLE at edge n drives mem_* from cycle n+1.
- Completion: x_ready is asserted in the same cycle as mem_ready (zero added latency).
- Gap between transactions: at least one IDLE cycle after each ready. The earliest next grant drives mem_* two cycles after the ready cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. slow_memory must also be reset or drained by the system.
- Simultaneous new request from the loser while the owner is completing: the loser is granted from the IDLE cycle, because last_owner already points at the finished side.

## Configuration
- MEMARB_DPRIO_EN defined: fixed priority. D-side always wins a tie in IDLE; last_owner is ignored (still updated for debug).
- MEMARB_DPRIO_EN undefined: round-robin as described above.
- Ports, latency and reset behaviour are identical in both builds.

## Structure
- Package mem_arb_pkg holds:
  - state encoding (IDLE, BUSY_I, BUSY_D)
  - owner encodings
  - default ADDR_W and LINE_W constants
- One sub-module, arb_rr_pick2: purely combinational 2-way picker. Inputs: req[1:0], last_owner, prio mode. Output: one-hot grant. The FSM and datapath muxes stay in mem_arbiter.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both sides requesting -> all outputs 0, owner=00; release -> I is granted first (owner=01 one cycle later).
- Lone D read to addr 28'h0000100 with a memory latency of 4 -> mem_read=1 and mem_addr=28'h0000100; d_ready pulses once with d_rdata=mem_rdata; i_ready stays 0.
- Both sides request continuously with round-robin -> grant order I, D, I, D; each grant is preceded by exactly one IDLE cycle.
- Same as the previous scenario with MEMARB_DPRIO_EN defined -> D granted every time; I is starved while D requests.
- D write of 128'hA5 repeated to addr 28'h10 during an active I read -> the write starts only after i_ready; mem_wdata matches the written line and mem_write=1.
- I drops i_read mid-BUSY_I -> next state IDLE, owner=00, last_owner unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the two-port line arbiter
//                that sits between the I/D L2 caches and slow_memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Default line address width (byte address bits 31:4) and line width
    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned LINE_W_DEF = 128;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // Encoding presented on the owner output
    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_I    = 2'b01;
    localparam logic [1:0] OWNER_D    = 2'b10;

    // Encoding of the last_owner register
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr_pick2
//  Description : Combinational 2-way picker. req_i[0] is the I side and
//                req_i[1] the D side. A tie goes to the side that did not
//                finish last, or always to D when dprio_i is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    input  logic       dprio_i,
    output logic [1:0] gnt_o
);

    // One-hot grant from the request vector, tie broken by mode/history
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (dprio_i || (last_owner_i == LAST_I)) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one slow_memory line port between the I-side and
//                D-side L2 caches, one 128-bit line transaction at a time.
//                Round-robin by default; define MEMARB_DPRIO_EN to give the
//                D side fixed priority on ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-side L2
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    // D-side L2
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    // slow_memory
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // Current grant
    output logic [1:0]        owner
);

`ifdef MEMARB_DPRIO_EN
    localparam logic DPRIO = 1'b1;
`else
    localparam logic DPRIO = 1'b0;
`endif

    arb_state_e state_q;
    logic       last_owner_q;
    logic [1:0] owner_q;

    logic       w_req_i;
    logic       w_req_d;
    logic [1:0] w_gnt;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;
    assign owner   = owner_q;

    arb_rr_pick2 u_pick (
        .req_i        ({w_req_d, w_req_i}),
        .last_owner_i (last_owner_q),
        .dprio_i      (DPRIO),
        .gnt_o        (w_gnt)
    );

    // Grant FSM: one transaction at a time, always returning through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= LAST_D;
            owner_q      <= OWNER_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_gnt[0]) begin
                        state_q <= ST_BUSY_I;
                        owner_q <= OWNER_I;
                    end else if (w_gnt[1]) begin
                        state_q <= ST_BUSY_D;
                        owner_q <= OWNER_D;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ready) begin
                        state_q      <= ST_IDLE;
                        owner_q      <= OWNER_IDLE;
                        last_owner_q <= LAST_I;
                    end else if (!w_req_i) begin
                        // Requester withdrew: abandon without touching history
                        state_q <= ST_IDLE;
                        owner_q <= OWNER_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ready) begin
                        state_q      <= ST_IDLE;
                        owner_q      <= OWNER_IDLE;
                        last_owner_q <= LAST_D;
                    end else if (!w_req_d) begin
                        state_q <= ST_IDLE;
                        owner_q <= OWNER_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWNER_IDLE;
                end
            endcase
        end
    end

    // Zero-latency routing between the owning side and slow_memory
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdata   = '0;
        i_ready   = 1'b0;
        d_rdata   = '0;
        d_ready   = 1'b0;
        case (state_q)
            ST_BUSY_I: begin
                mem_read  = i_read;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_rdata   = mem_rdata;
                i_ready   = mem_ready;
            end
            ST_BUSY_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_rdata   = mem_rdata;
                d_ready   = mem_ready;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Requester processes drive
//                queued line commands on each side, a latency-4 memory model
//                answers, and a monitor checks every ready and every grant
//                against expectations queued when the stimulus is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW      = 28;
    localparam int LW      = 128;
    localparam int MEM_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_wdata = '0;
    logic [LW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [7:0]    abort_cyc;   // 0 = run to completion
    } cmd_t;

    typedef struct packed {
        logic [1:0] own;
        int         gap;            // required IDLE cycles before grant, -1 = any
    } gnt_t;

    cmd_t i_cmdq[$], d_cmdq[$], i_expq[$], d_expq[$];
    gnt_t gnt_expq[$];

    int total = 0;
    int bad   = 0;

`ifdef MEMARB_DPRIO_EN
    localparam bit DPRIO = 1'b1;
`else
    localparam bit DPRIO = 1'b0;
`endif

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
    endfunction

    function automatic cmd_t mk(input logic wr, input logic [AW-1:0] a,
                                input logic [LW-1:0] wd, input logic [7:0] ab);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = wd; c.abort_cyc = ab;
        return c;
    endfunction

    function automatic gnt_t mg(input logic [1:0] o, input int g);
        gnt_t x;
        x.own = o; x.gap = g;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    // Memory model: ready in the MEM_LAT-th cycle of a continuous request
    initial begin
        int            cnt;
        logic          busy, rdy;
        logic [AW-1:0] a;
        cnt = 0;
        forever begin
            @(posedge clk);
            busy = mem_read | mem_write;
            rdy  = mem_ready;
            a    = mem_addr;
            #1;
            if (!busy || rdy) begin
                cnt       = 0;
                mem_ready = 1'b0;
                mem_rdata = '0;
            end else begin
                cnt++;
                if (cnt == MEM_LAT - 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = pat(a);
                end
            end
        end
    end

    // I-side requester: holds each command until i_ready (or aborts)
    initial begin
        cmd_t c;
        forever begin
            @(posedge clk); #1;
            if (i_cmdq.size() != 0) begin
                c = i_cmdq.pop_front();
                i_read = ~c.wr; i_write = c.wr; i_addr = c.addr; i_wdata = c.wdata;
                if (c.abort_cyc == 8'd0) begin
                    bit got;
                    got = 1'b0;
                    i_expq.push_back(c);
                    for (int n = 0; n < 200 && !got; n++) begin
                        @(negedge clk);
                        got = i_ready;
                    end
                    if (!got) timeout("i_ready");
                end else begin
                    int seen;
                    seen = 0;
                    for (int n = 0; n < 200 && seen < int'(c.abort_cyc); n++) begin
                        @(negedge clk);
                        if (owner == OWNER_I) seen++;
                    end
                    if (seen < int'(c.abort_cyc)) timeout("i_abort_grant");
                end
            end else begin
                i_read = 1'b0; i_write = 1'b0;
            end
        end
    end

    // D-side requester: same behaviour as the I side
    initial begin
        cmd_t c;
        forever begin
            @(posedge clk); #1;
            if (d_cmdq.size() != 0) begin
                bit got;
                c = d_cmdq.pop_front();
                d_read = ~c.wr; d_write = c.wr; d_addr = c.addr; d_wdata = c.wdata;
                got = 1'b0;
                d_expq.push_back(c);
                for (int n = 0; n < 200 && !got; n++) begin
                    @(negedge clk);
                    got = d_ready;
                end
                if (!got) timeout("d_ready");
            end else begin
                d_read = 1'b0; d_write = 1'b0;
            end
        end
    end

    // Monitor: checks completions and grant order/spacing mid-cycle
    initial begin
        cmd_t       e;
        gnt_t       g;
        logic [1:0] prev_owner;
        int         idle_run;
        prev_owner = 2'b00;
        idle_run   = 0;
        forever begin
            @(negedge clk);
            if (i_ready) begin
                if (i_expq.size() == 0) begin
                    chk("i_ready_unexpected", i_ready, 1'b0);
                end else begin
                    e = i_expq.pop_front();
                    chk("i_rdata", i_rdata, pat(e.addr));
                    chk("i_mem_addr", mem_addr, e.addr);
                    chk("i_mem_rw", {mem_read, mem_write}, {~e.wr, e.wr});
                    chk("i_mem_wdata", mem_wdata, e.wdata);
                    chk("i_d_ready_quiet", d_ready, 1'b0);
                    chk("i_d_rdata_quiet", d_rdata, '0);
                end
            end
            if (d_ready) begin
                if (d_expq.size() == 0) begin
                    chk("d_ready_unexpected", d_ready, 1'b0);
                end else begin
                    e = d_expq.pop_front();
                    chk("d_rdata", d_rdata, pat(e.addr));
                    chk("d_mem_addr", mem_addr, e.addr);
                    chk("d_mem_rw", {mem_read, mem_write}, {~e.wr, e.wr});
                    chk("d_mem_wdata", mem_wdata, e.wdata);
                    chk("d_i_ready_quiet", i_ready, 1'b0);
                    chk("d_i_rdata_quiet", i_rdata, '0);
                end
            end
            if (owner != 2'b00 && prev_owner == 2'b00) begin
                if (gnt_expq.size() == 0) begin
                    chk("grant_unexpected", owner, 2'b00);
                end else begin
                    g = gnt_expq.pop_front();
                    chk("grant_owner", owner, g.own);
                    if (g.gap >= 0) chk("grant_gap", idle_run, g.gap);
                end
            end
            if (owner == 2'b00) idle_run++;
            else                idle_run = 0;
            prev_owner = owner;
        end
    end

    task automatic wait_owner(input logic [1:0] o, input string nm);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            hit = (owner == o);
        end
        if (!hit) timeout(nm);
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done = (i_cmdq.size() == 0) && (d_cmdq.size() == 0) &&
                   (i_expq.size() == 0) && (d_expq.size() == 0) &&
                   (gnt_expq.size() == 0) && !mem_read && !mem_write;
        end
        if (!done) timeout(nm);
        repeat (3) @(negedge clk);
    endtask

    // Directed scenarios
    initial begin
        // Reset held with both sides requesting
        rst_n = 1'b0;
        i_cmdq.push_back(mk(1'b0, 28'h0000A00, '0, 8'd0));
        i_cmdq.push_back(mk(1'b0, 28'h0000A10, '0, 8'd0));
        d_cmdq.push_back(mk(1'b0, 28'h0000B00, '0, 8'd0));
        d_cmdq.push_back(mk(1'b0, 28'h0000B10, '0, 8'd0));
        if (DPRIO) begin
            gnt_expq.push_back(mg(OWNER_D, -1));
            gnt_expq.push_back(mg(OWNER_D, 1));
            gnt_expq.push_back(mg(OWNER_I, 1));
            gnt_expq.push_back(mg(OWNER_I, 1));
        end else begin
            gnt_expq.push_back(mg(OWNER_I, -1));
            gnt_expq.push_back(mg(OWNER_D, 1));
            gnt_expq.push_back(mg(OWNER_I, 1));
            gnt_expq.push_back(mg(OWNER_D, 1));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ctrl", {mem_read, mem_write, i_ready, d_ready, owner}, '0);
            chk("rst_mem_addr", mem_addr, '0);
            chk("rst_mem_wdata", mem_wdata, '0);
            chk("rst_rdata", i_rdata | d_rdata, '0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("owner_pre_grant", owner, OWNER_IDLE);
        @(negedge clk);
        chk("first_grant", owner, DPRIO ? OWNER_D : OWNER_I);
        drain("drain_rr");

        // Lone D read
        gnt_expq.push_back(mg(OWNER_D, -1));
        d_cmdq.push_back(mk(1'b0, 28'h0000100, '0, 8'd0));
        drain("drain_lone_d");

        // D write arriving while an I read is in flight
        gnt_expq.push_back(mg(OWNER_I, -1));
        gnt_expq.push_back(mg(OWNER_D, 1));
        i_cmdq.push_back(mk(1'b0, 28'h0000020, '0, 8'd0));
        wait_owner(OWNER_I, "wait_i_busy");
        d_cmdq.push_back(mk(1'b1, 28'h0000010, 128'hA5, 8'd0));
        drain("drain_wr");

        // I withdraws mid-transaction; history must still say D finished last
        gnt_expq.push_back(mg(OWNER_I, -1));
        i_cmdq.push_back(mk(1'b0, 28'h0000030, '0, 8'd2));
        wait_owner(OWNER_I, "wait_abort_grant");
        begin
            bit dropped;
            dropped = 1'b0;
            for (int n = 0; n < 50 && !dropped; n++) begin
                @(negedge clk);
                dropped = !i_read;
            end
            if (!dropped) timeout("wait_i_drop");
        end
        chk("abort_mem_read", mem_read, 1'b0);
        @(negedge clk);
        chk("abort_owner_idle", owner, OWNER_IDLE);
        if (DPRIO) begin
            gnt_expq.push_back(mg(OWNER_D, -1));
            gnt_expq.push_back(mg(OWNER_I, 1));
        end else begin
            gnt_expq.push_back(mg(OWNER_I, -1));
            gnt_expq.push_back(mg(OWNER_D, 1));
        end
        i_cmdq.push_back(mk(1'b0, 28'h0000040, '0, 8'd0));
        d_cmdq.push_back(mk(1'b0, 28'h0000050, '0, 8'd0));
        drain("drain_tie");

        chk("left_i_exp", i_expq.size(), 0);
        chk("left_d_exp", d_expq.size(), 0);
        chk("left_grants", gnt_expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global safety net
    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
